// File: rtl/seg_pkg.sv
// Shared constants for the scrolling seven-segment display: character codes,
// buffer depth and active-low {g,f,e,d,c,b,a} glyph patterns.
package seg_pkg;

    localparam int unsigned MSG_DEPTH = 16;
    localparam int unsigned CODE_W    = 5;
    localparam int unsigned SEG_W     = 7;

    localparam logic [CODE_W-1:0] CH_BLANK = 5'd16;
    localparam logic [CODE_W-1:0] CH_DASH  = 5'd17;

    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'b0111111;

    // Hex glyphs, element 0 is the rightmost entry of the concatenation
    localparam logic [15:0][SEG_W-1:0] GLYPH_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational character-code to active-low segment pattern mapping.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SEG_W-1:0]  glyph_c
);

    // Codes 18..31 fall through to blank
    always_comb begin
        glyph_c = GLYPH_BLANK;
        if (code < 5'd16) begin
            glyph_c = GLYPH_HEX[code[3:0]];
        end else if (code == CH_DASH) begin
            glyph_c = GLYPH_DASH;
        end
    end

endmodule

// File: rtl/seg_scroll_display.sv
// Four-digit multiplexed seven-segment driver with a 16-entry scrolling
// message buffer; scroll steps come from an external divider tick.
module seg_scroll_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned MSG_DEPTH   = seg_pkg::MSG_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       scroll_en,
    input  logic [4:0] msg_len,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [4:0] wr_data,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       wrap
);

    import seg_pkg::*;

    localparam int unsigned RCNT_W = $clog2(REFRESH_DIV);

    logic [CODE_W-1:0] msg_buf [MSG_DEPTH];
    logic [3:0]        pos;
    logic [1:0]        dsel;
    logic [RCNT_W-1:0] rcnt;

    logic [4:0]        len_eff_c;
    logic [3:0]        slot_idx_c;
    logic [CODE_W-1:0] code_c;
    logic [SEG_W-1:0]  glyph_c;
    logic              out_of_range_c;
    logic              step_c;
    logic              last_c;

    // Clamp the requested length into 4..16
    always_comb begin
        len_eff_c = msg_len;
        if (msg_len < 5'd4) begin
            len_eff_c = 5'd4;
        end else if (msg_len > 5'd16) begin
            len_eff_c = 5'd16;
        end
    end

    assign out_of_range_c = 5'(pos) >= len_eff_c;
    assign step_c         = tick_in & scroll_en;
    assign last_c         = 5'(pos) == (len_eff_c - 5'd1);

    // Slot k shows buf[(pos + 3 - k) mod len]; 5-bit sum avoids aliasing
    assign slot_idx_c = 4'((5'(pos) + 5'd3 - 5'(dsel)) % len_eff_c);
    assign code_c     = msg_buf[slot_idx_c];

    seg_glyph_decode u_glyph (
        .code    (code_c),
        .glyph_c (glyph_c)
    );

    assign dp = 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            msg_buf <= '{default: CH_BLANK};
            pos     <= '0;
            dsel    <= '0;
            rcnt    <= '0;
            an      <= 4'b1111;
            seg     <= GLYPH_BLANK;
            wrap    <= 1'b0;
        end else begin
            if (wr_en) begin
                msg_buf[wr_addr] <= wr_data;
            end

            // Out-of-range correction outranks a tick and never pulses wrap
            wrap <= 1'b0;
            if (out_of_range_c) begin
                pos <= '0;
            end else if (step_c) begin
                if (last_c) begin
                    pos  <= '0;
                    wrap <= 1'b1;
                end else begin
                    pos <= pos + 4'd1;
                end
            end

            if (rcnt == RCNT_W'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                dsel <= dsel + 2'd1;
            end else begin
                rcnt <= rcnt + RCNT_W'(1);
            end

            an  <= ~(4'b0001 << dsel);
            seg <= glyph_c;
        end
    end

endmodule

// File: tb/tb_seg_scroll_display.sv
// Randomized and directed bench for seg_scroll_display against a cycle-level
// behavioural model of the scan, scroll and buffer rules.
module tb_seg_scroll_display;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_in = 1'b0;
    logic       scroll_en = 1'b0;
    logic [4:0] msg_len = 5'd4;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [4:0] wr_data = 5'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       wrap;

    seg_scroll_display #(.REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_in   (tick_in),
        .scroll_en (scroll_en),
        .msg_len   (msg_len),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wrap   = 0;

    int       m_buf [16];
    int       m_pos = 0;
    int       m_cyc = 0;
    logic [6:0] obs_seg [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int code);
        case (code)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  15: return 7'b0001110;
            17: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int clamp_len(input int l);
        if (l < 4) return 4;
        if (l > 16) return 16;
        return l;
    endfunction

    // One clock: predict outputs from model state and inputs, advance, compare
    task automatic cycle();
        int len, slot;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic exp_wrap;
        len  = clamp_len(int'(msg_len));
        slot = -1;
        if (!reset) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_wrap = 1'b0;
        end else begin
            slot     = (m_cyc / RD) % 4;
            exp_an   = ~(4'(1) << slot);
            exp_seg  = glyph(m_buf[(m_pos + 3 - slot) % len]);
            exp_wrap = (m_pos == len - 1) && tick_in && scroll_en;
        end
        @(posedge clk);
        #1;
        if (!reset) begin
            foreach (m_buf[i]) m_buf[i] = 16;
            m_pos = 0;
            m_cyc = 0;
        end else begin
            if (wr_en) m_buf[wr_addr] = int'(wr_data);
            if (m_pos >= len) m_pos = 0;
            else if (tick_in && scroll_en) m_pos = (m_pos + 1) % len;
            m_cyc++;
        end
        check_eq("an", 32'(an), 32'(exp_an));
        check_eq("seg", 32'(seg), 32'(exp_seg));
        check_eq("dp", 32'(dp), 32'd1);
        check_eq("wrap", 32'(wrap), 32'(exp_wrap));
        if (wrap === 1'b1) n_wrap++;
        if (slot >= 0) obs_seg[slot] = seg;
    endtask

    task automatic idle(input int n);
        tick_in = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic tick_once();
        tick_in = 1'b1; cycle(); tick_in = 1'b0;
    endtask

    task automatic write(input int a, input int d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = 5'(d);
        cycle();
        wr_en = 1'b0;
    endtask

    initial begin
        int w0;
        foreach (m_buf[i]) m_buf[i] = 16;
        foreach (obs_seg[i]) obs_seg[i] = 7'h00;

        // Reset held three cycles, then blank scan
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        cycle();
        check_eq("first_an", 32'(an), 32'(4'b1110));
        idle(15);

        // Static display
        msg_len = 5'd4;
        for (int i = 0; i < 4; i++) write(i, i + 1);
        idle(16);
        check_eq("static_slot3", 32'(obs_seg[3]), 32'(7'b1111001));
        check_eq("static_slot0", 32'(obs_seg[0]), 32'(7'b0011001));

        // Scroll with wrap, mixing spaced and back-to-back ticks
        msg_len = 5'd6;
        for (int i = 0; i < 6; i++) write(i, i);
        scroll_en = 1'b1;
        w0 = n_wrap;
        tick_once(); tick_once(); idle(2); tick_once(); tick_once(); idle(3); tick_once();
        idle(16);
        check_eq("scroll_s3", 32'(obs_seg[3]), 32'(7'b0010010));
        check_eq("scroll_s2", 32'(obs_seg[2]), 32'(7'b1000000));
        check_eq("scroll_s1", 32'(obs_seg[1]), 32'(7'b1111001));
        check_eq("scroll_s0", 32'(obs_seg[0]), 32'(7'b0100100));
        tick_once();
        idle(2);
        check_eq("scroll_wraps", 32'(n_wrap - w0), 32'd1);

        // Length shrink with pos = 10
        msg_len = 5'd16;
        for (int i = 0; i < 10; i++) tick_once();
        w0 = n_wrap;
        msg_len = 5'd8;
        idle(16);
        check_eq("shrink_wrap", 32'(n_wrap - w0), 32'd0);
        check_eq("shrink_s3", 32'(obs_seg[3]), 32'(7'b1000000));

        // Clamp to 4 and scroll gating
        msg_len = 5'd2;
        w0 = n_wrap;
        for (int i = 0; i < 4; i++) begin tick_once(); idle(1); end
        idle(2);
        check_eq("clamp_wraps", 32'(n_wrap - w0), 32'd1);
        scroll_en = 1'b0;
        for (int i = 0; i < 5; i++) tick_once();
        idle(16);
        check_eq("gated_s3", 32'(obs_seg[3]), 32'(7'b1000000));

        // Write and tick in the same cycle
        scroll_en = 1'b1;
        tick_in = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 5'd17;
        cycle();
        idle(16);
        check_eq("concur_s3", 32'(obs_seg[3]), 32'(7'b0111111));

        // Reset mid-scan
        idle(5);
        reset = 1'b0;
        cycle();
        check_eq("midrst_an", 32'(an), 32'hF);
        reset = 1'b1;
        idle(16);
        for (int k = 0; k < 4; k++) check_eq("midrst_blank", 32'(obs_seg[k]), 32'h7F);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom_range(0, 299) != 0);
            tick_in   = ($urandom_range(0, 2) == 0);
            scroll_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) msg_len = 5'($urandom_range(0, 31));
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 5'($urandom_range(0, 31));
            cycle();
        end
        reset = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
